// File: rtl/dwt_coef_serializer.sv
// dwt_coef_serializer
// Captures one (a, d) coefficient pair per clk2 rising phase, buffers pairs in a
// small FIFO and streams them out as 16-bit words (a then d) on a valid/ready port,
// tagged by sub-band and marking the d word of the last pair of each frame.
//
// state  | meaning
// IDLE   | no word presented, waiting for a buffered pair
// SEND_A | approximation word of the held pair presented on out_data
// SEND_D | detail word of the held pair presented on out_data
module dwt_coef_serializer #(
    parameter int W         = 16,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk2,
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    d,
    output logic [W-1:0]           out_data,
    output logic                   out_sub,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_D = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic           c2_q1, c2_q2;
    logic           cap;
    logic           wr_en;
    logic           pop;
    logic           accept;
    logic [2*W-1:0] mem [DEPTH];
    logic [2*W-1:0] rd_pair;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [W-1:0]   hold_d, hold_d_nx;
    logic [FCW-1:0] frame_cnt, frame_nx;
    logic [W-1:0]   data_nx;
    logic           sub_nx, last_nx, valid_nx;

    assign cap     = c2_q1 & ~c2_q2;
    // A full FIFO drops the pair even if a pop happens on the same edge.
    assign wr_en   = cap && (fill != FW'(DEPTH));
    assign accept  = out_valid & out_ready;
    assign rd_pair = mem[rd_ptr];

    // clk2 is only a data signal here; a rising phase yields a one-clk capture strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c2_q1 <= 1'b0;
            c2_q2 <= 1'b0;
        end else begin
            c2_q1 <= clk2;
            c2_q2 <= c2_q1;
        end
    end

    // FIFO storage: no reset needed, contents are qualified by fill.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {a, d};
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            if (cap && !wr_en) overflow <= 1'b1;
        end
    end

    // State register plus the registered output word, hold register and frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_data  <= '0;
            out_sub   <= 1'b0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            hold_d    <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            out_data  <= data_nx;
            out_sub   <= sub_nx;
            out_last  <= last_nx;
            out_valid <= valid_nx;
            hold_d    <= hold_d_nx;
            frame_cnt <= frame_nx;
        end
    end

    // Next-state and next-output logic; outputs hold unless a handshake or pop moves them.
    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        data_nx   = out_data;
        sub_nx    = out_sub;
        last_nx   = out_last;
        valid_nx  = out_valid;
        hold_d_nx = hold_d;
        frame_nx  = frame_cnt;
        case (state)
            IDLE: begin
                if (fill != '0) begin
                    pop       = 1'b1;
                    data_nx   = rd_pair[2*W-1:W];
                    hold_d_nx = rd_pair[W-1:0];
                    sub_nx    = 1'b0;
                    last_nx   = 1'b0;
                    valid_nx  = 1'b1;
                    state_nx  = SEND_A;
                end
            end
            SEND_A: begin
                if (accept) begin
                    data_nx  = hold_d;
                    sub_nx   = 1'b1;
                    last_nx  = (frame_cnt == FCW'(FRAME_LEN - 1));
                    state_nx = SEND_D;
                end
            end
            SEND_D: begin
                if (accept) begin
                    frame_nx = out_last ? '0 : frame_cnt + FCW'(1);
                    if (fill != '0) begin
                        // Back-to-back: next pair's a word follows without a bubble.
                        pop       = 1'b1;
                        data_nx   = rd_pair[2*W-1:W];
                        hold_d_nx = rd_pair[W-1:0];
                        sub_nx    = 1'b0;
                        last_nx   = 1'b0;
                        state_nx  = SEND_A;
                    end else begin
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                last_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dwt_coef_serializer.sv
// Bench for dwt_coef_serializer: queue-based scoreboard fed at stimulus time,
// independent monitor comparing every accepted output word.
module tb_dwt_coef_serializer;

    localparam int W         = 16;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   clk2 = 1'b0;
    logic signed [W-1:0]    a = '0;
    logic signed [W-1:0]    d = '0;
    logic [W-1:0]           out_data;
    logic                   out_sub;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [$clog2(DEPTH):0] fill;
    logic                   overflow;

    int checks = 0;
    int errors = 0;
    int last_cnt = 0;
    int mframe = 0;
    logic [W+1:0] exp_q[$];

    bit rdy_rand = 1'b0;
    bit rdy_fix  = 1'b0;

    dwt_coef_serializer #(.W(W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk2      (clk2),
        .a         (a),
        .d         (d),
        .out_data  (out_data),
        .out_sub   (out_sub),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Sink readiness, changed just after each falling edge.
    always begin
        @(negedge clk);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    // Reference model: a stream of pairs becomes a then d, frame counts pairs.
    task automatic push_pair(input logic [W-1:0] pa, input logic [W-1:0] pd);
        bit lst;
        lst = (mframe == FRAME_LEN - 1);
        exp_q.push_back({pa, 1'b0, 1'b0});
        exp_q.push_back({pd, 1'b1, lst});
        mframe = lst ? 0 : mframe + 1;
    endtask

    task automatic send_pair(input logic [W-1:0] pa, input logic [W-1:0] pd,
                             input int hi, input int lo, input bit expect_kept);
        @(negedge clk);
        a    = pa;
        d    = pd;
        clk2 = 1'b1;
        if (expect_kept) push_pair(pa, pd);
        repeat (hi) @(negedge clk);
        clk2 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset(input bit verify);
        @(negedge clk);
        rst = 1'b0;
        #2;
        if (verify) begin
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_data", 32'(out_data), 32'd0);
            check("rst_sub", 32'(out_sub), 32'd0);
            check("rst_last", 32'(out_last), 32'd0);
            check("rst_fill", 32'(fill), 32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
        end
        repeat (2) @(negedge clk);
        exp_q.delete();
        mframe   = 0;
        last_cnt = 0;
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares each handshaken word with the scoreboard head and
    // checks that a stalled word does not change.
    logic [W-1:0] p_data;
    logic         p_sub, p_last;
    bit           stall_p = 1'b0;
    always begin
        logic [W+1:0] e;
        @(negedge clk);
        #2;
        if (!rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === p_data &&
                      out_sub === p_sub && out_last === p_last)) begin
                    errors++;
                    $display("FAIL stall_stable actual=%b/%h/%b/%b required=1/%h/%b/%b",
                             out_valid, out_data, out_sub, out_last, p_data, p_sub, p_last);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h/%b/%b required=none",
                             out_data, out_sub, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_sub, out_last} !== e) begin
                        errors++;
                        $display("FAIL word actual=%h/%b/%b required=%h/%b/%b",
                                 out_data, out_sub, out_last, e[W+1:2], e[1], e[0]);
                    end
                end
                if (out_last) last_cnt++;
            end
            stall_p = out_valid && !out_ready;
            p_data  = out_data;
            p_sub   = out_sub;
            p_last  = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_fill", 32'(fill), 32'd0);
        check("init_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rdy_fix = 1'b1;
        repeat (3) @(negedge clk);

        // Latency: write on edge E, word visible after E+1, then d, then idle
        @(negedge clk);
        a = 16'h0123;
        d = 16'hFEDC;
        clk2 = 1'b1;
        push_pair(16'h0123, 16'hFEDC);
        @(negedge clk);
        clk2 = 1'b0;
        #2;
        check("lat_fill0", 32'(fill), 32'd0);
        check("lat_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("lat_fill1", 32'(fill), 32'd1);
        check("lat_valid1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("lat_valid2", 32'(out_valid), 32'd1);
        check("lat_a", 32'({out_data, out_sub}), 32'({16'h0123, 1'b0}));
        @(negedge clk);
        #2;
        check("lat_d", 32'({out_valid, out_data, out_sub}), 32'({1'b1, 16'hFEDC, 1'b1}));
        @(negedge clk);
        #2;
        check("lat_idle", 32'(out_valid), 32'd0);
        wait_drain("lat_drain");

        // Framing: 9 pairs, last flags on d of pairs 4 and 8
        do_reset(1'b0);
        for (int i = 1; i <= 9; i++)
            send_pair(16'(16'h1000 + i), 16'(16'h2000 + i), 1, 1, 1'b1);
        wait_drain("frame_drain");
        check("frame_last_cnt", 32'(last_cnt), 32'd2);

        // Backpressure: stalled word stays put, later pairs queue up
        rdy_fix = 1'b0;
        for (int i = 0; i < 3; i++)
            send_pair(16'(16'h3000 + i), 16'(16'h4000 - i), 1, 1, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_fill", 32'(fill), 32'd2);
        rdy_fix = 1'b1;
        wait_drain("bp_drain");

        // Overflow: 10 pairs into a stalled sink, pair 10 is dropped
        rdy_fix = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send_pair(16'(16'h5000 + i), 16'(16'h6000 + i), 1, 1, i <= 9);
            if (i == 9) begin
                #2;
                check("ovf_before", 32'(overflow), 32'd0);
            end
        end
        #2;
        check("ovf_fill", 32'(fill), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        rdy_fix = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of traffic clears everything including overflow
        rdy_fix = 1'b0;
        for (int i = 0; i < 3; i++)
            send_pair(16'(16'h7000 + i), 16'(16'h7100 + i), 1, 1, 1'b1);
        do_reset(1'b1);
        rdy_fix = 1'b1;
        repeat (3) @(negedge clk);

        // Random sink with a ramp, pair rate kept below average drain rate
        rdy_rand = 1'b1;
        for (int n = 1; n <= 200; n++)
            send_pair(16'(n), 16'(0 - n), $urandom_range(1, 3), $urandom_range(4, 6), 1'b1);
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        wait_drain("rand_drain");
        check("rand_overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
